// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Holds the PC, resolves redirects from decode, and supports stall, halt and reset.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned IM_ADDR_W = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 halt,
  input  logic                 jmp,
  input  logic                 jr,
  input  logic                 branch_taken,
  input  logic [31:0]          branch_offset,
  input  logic [31:0]          jaddr,
  output logic [IM_ADDR_W-1:0] imem_addr,
  input  logic [31:0]          imem_data,
  output logic [31:0]          IR,
  output logic [31:0]          PC_out,
  output logic [31:0]          PC4_out,
  output logic                 valid,
  output logic                 halted,
  output logic [31:0]          fetch_count
);

  logic [31:0] pc_q;
  logic [31:0] ir_q;
  logic [31:0] pc_out_q;
  logic [31:0] pc4_out_q;
  logic        valid_q;
  logic        halted_q;
  logic [31:0] count_q;

  logic        redirect;
  logic [31:0] pc_plus4;
  logic [31:0] redirect_pc;

  assign pc_plus4 = pc_q + 32'd4;

  // Redirects only mean something when decode holds a real instruction.
  assign redirect = valid_q & (jr | jmp | branch_taken);

  always_comb begin
    redirect_pc = pc_plus4;
    if (jr) begin
      redirect_pc = {jaddr[31:2], 2'b00};
    end else if (jmp) begin
      redirect_pc = {pc4_out_q[31:28], jaddr[25:0], 2'b00};
    end else if (branch_taken) begin
      redirect_pc = pc4_out_q + {branch_offset[29:0], 2'b00};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      ir_q      <= 32'd0;
      pc_out_q  <= 32'd0;
      pc4_out_q <= 32'd0;
      valid_q   <= 1'b0;
      halted_q  <= 1'b0;
      count_q   <= 32'd0;
    end else if (halted_q) begin
      // Frozen until reset.
    end else if (halt) begin
      halted_q <= 1'b1;
      ir_q     <= 32'd0;
      valid_q  <= 1'b0;
    end else if (stall) begin
      // Hold PC and IF/ID; decode re-presents any redirect afterwards.
    end else if (redirect) begin
      pc_q      <= redirect_pc;
      ir_q      <= 32'd0;
      pc_out_q  <= 32'd0;
      pc4_out_q <= 32'd0;
      valid_q   <= 1'b0;
    end else begin
      pc_q      <= pc_plus4;
      ir_q      <= imem_data;
      pc_out_q  <= pc_q;
      pc4_out_q <= pc_plus4;
      valid_q   <= 1'b1;
      count_q   <= count_q + 32'd1;
    end
  end

  assign imem_addr   = pc_q[IM_ADDR_W+1:2];
  assign IR          = ir_q;
  assign PC_out      = pc_out_q;
  assign PC4_out     = pc4_out_q;
  assign valid       = valid_q;
  assign halted      = halted_q;
  assign fetch_count = count_q;

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register. It sits directly upstream of the decode stage.
- Holds the PC and drives the instruction-memory word address.
- Latches the fetched instruction into IR, with its PC and PC+4, for decode.
- Resolves redirects from decode: jump, jump-register and taken branch. Also handles stall, flush and a sticky halt raised by decode on an exit syscall.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IM_ADDR_W, 10, width of the instruction-memory word address.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-high.
- stall  in  1  hazard hold from decode; freezes PC and IF/ID.
- halt  in  1  exit request from decode; sets the sticky halted state.
- jmp  in  1  decode holds J/JAL; target built from jaddr[25:0].
- jr  in  1  decode holds JR; target is jaddr (register value).
- branch_taken  in  1  decode holds a taken branch.
- branch_offset  in  32  sign-extended immediate of that branch.
- jaddr  in  32  jump address from decode.
- imem_addr  out  IM_ADDR_W  equals PC[IM_ADDR_W+1:2]; combinational.
- imem_data  in  32  instruction word; combinational read of imem_addr.
- IR  out  32  instruction presented to decode.
- PC_out  out  32  PC of the instruction in IR.
- PC4_out  out  32  PC_out + 4.
- valid  out  1  IR holds a real instruction (0 means bubble).
- halted  out  1  sticky halt flag.
- fetch_count  out  32  number of instructions latched into IF/ID.

Behaviour:
- Reset values:
  - PC = RESET_PC.
  - IR = 0, PC_out = 0, PC4_out = 0.
  - valid = 0, halted = 0, fetch_count = 0.
- rst has priority over every other input in the same cycle, including mid-stall, mid-redirect and while halted.
- Update priority per posedge: rst > halted > halt > stall > jr > jmp > branch_taken > sequential.
  - halted = 1: PC, IR, PC_out, PC4_out, valid and fetch_count all hold.
  - halt = 1: halted <= 1; PC holds; IR <= 0; valid <= 0.
  - stall = 1: PC and the whole IF/ID register hold; count holds. Redirect inputs are ignored. Decode re-asserts them after the stall because it is frozen too.
  - jr = 1: PC <= {jaddr[31:2], 2'b00}; misaligned bits are dropped.
  - jmp = 1: PC <= {PC4_out[31:28], jaddr[25:0], 2'b00}.
  - branch_taken = 1: PC <= PC4_out + (branch_offset << 2), modulo 2^32.
  - On any redirect (jr, jmp or branch_taken): IR <= 0 (NOP), valid <= 0, PC_out/PC4_out <= 0. This is a one-cycle bubble; the delay-slot instruction is squashed.
  - Sequential case:
    - IR <= imem_data.
    - PC_out <= PC, PC4_out <= PC + 4.
    - valid <= 1; fetch_count <= fetch_count + 1.
    - PC <= PC + 4.
- Latency: an instruction at address A appears in IR one cycle after PC = A.
- Wrap-around:
  - PC + 4 wraps at 2^32.
  - fetch_count wraps from 0xFFFF_FFFF to 0.
- Redirect inputs are only meaningful while valid = 1. With valid = 0 they are ignored: PC advances sequentially.
- Simultaneous jr, jmp and branch_taken: resolved by the fixed priority above. Decode is not expected to produce this.

Test Plan:
- Reset, sequential fetch: imem[k] = 0x1000_0000 + k, no stalls.
  - After edge 3: PC = 0x0C, IR = 0x1000_0002, PC_out = 0x08, PC4_out = 0x0C, valid = 1, fetch_count = 3.
- Jump: PC4_out = 0x0040_0014, jmp = 1, jaddr = 0x0010_0008, valid = 1.
  - Next edge: PC = 0x0040_0020, IR = 0, valid = 0.
  - Following edge: IR = imem at 0x0040_0020.
- Branch: PC4_out = 0x100, branch_taken = 1, branch_offset = 0xFFFF_FFFC.
  - Next edge: PC = 0xF0, valid = 0, fetch_count unchanged.
- JR misaligned and JR/branch priority: jr = 1, jaddr = 0x0000_0203, branch_taken = 1.
  - Next edge: PC = 0x200.
- Stall two cycles during sequential fetch with PC = 0x20.
  - PC, IR, PC_out and fetch_count unchanged for both edges.
  - Fetch resumes at 0x20 on the third edge.
  - stall = 1 together with jmp = 1: jump ignored.
- Halt then reset:
  - halt = 1 at PC = 0x40: halted = 1, valid = 0. PC stays 0x40 and count is frozen for 5 cycles despite stall/jmp toggling.
  - rst = 1: all outputs return to reset values, halted = 0.
